axil_adapter_wr: RTL and testbench
==================================

AXIL_ADAPTER_WR -- requirements
Module: axil_adapter_wr

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning address width.
REQ-002 SHALL have parameter S_DATA_WIDTH, default 32, meaning slave-side data width.
REQ-003 SHALL have parameter S_STRB_WIDTH, default S_DATA_WIDTH/8, meaning slave-side strobe width.
REQ-004 SHALL have parameter M_DATA_WIDTH, default 32, meaning master-side data width.
REQ-005 SHALL have parameter M_STRB_WIDTH, default M_DATA_WIDTH/8, meaning master-side strobe width.
REQ-006 SHALL have one clock and an asynchronous, active-low reset.
REQ-007 SHALL have the following ports, in this order:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- s_axil_awaddr/awprot/awvalid  in  ADDR_WIDTH/3/1; s_axil_awready  out  1.
- s_axil_wdata/wstrb/wvalid  in  S_DATA_WIDTH/S_STRB_WIDTH/1; s_axil_wready  out  1.
- s_axil_bresp/bvalid  out  2/1; s_axil_bready  in  1.
- m_axil_awaddr/awprot/awvalid  out  ADDR_WIDTH/3/1; m_axil_awready  in  1.
- m_axil_wdata/wstrb/wvalid  out  M_DATA_WIDTH/M_STRB_WIDTH/1; m_axil_wready  in  1.
- m_axil_bresp/bvalid  in  2/1; m_axil_bready  out  1.

Function
REQ-008 SHALL make all outputs registered (no combinational input-to-output path).
REQ-009 SHALL fail elaboration unless the word sizes match and both STRB widths are powers of two.
REQ-010 SHALL use the states IDLE, DATA and RESP.
REQ-011 IDLE: SHALL hold s_awready and s_wready high together only while m_awvalid, m_wvalid and s_bvalid are all low.
- A transfer SHALL be accepted only when awvalid and wvalid are both high with the readies high.
- The readies SHALL deassert on the cycle after acceptance.
REQ-012 On acceptance, SHALL assert m_awvalid and m_wvalid on the next cycle and enter DATA.
REQ-013 DATA: SHALL clear m_awvalid and m_wvalid independently on their own handshakes, holding payloads stable until then.
- Once both have handshaked, SHALL assert m_bready and enter RESP.
REQ-014 Same width or expand (M wider), single beat:
- m_awaddr SHALL equal s_awaddr.
- m_wdata SHALL replicate s_wdata in every segment.
- m_wstrb SHALL place s_wstrb in the segment selected by awaddr[M_OFFSET-1:S_OFFSET] and be zero elsewhere.
REQ-015 Narrow (S wider), SEGMENT_COUNT beats:
- The first address SHALL be s_awaddr aligned down to S_STRB_WIDTH.
- The address SHALL increment by M_STRB_WIDTH per beat.
- Beat k SHALL carry data segment k and strobe segment k.
- Every beat SHALL be issued, even with an all-zero strobe.
REQ-016 RESP: each m_bvalid&&m_bready SHALL drop m_bready.
- If beats remain, SHALL reassert m_awvalid/m_wvalid for the next beat and return to DATA.
- Otherwise, SHALL return to IDLE.
REQ-017 SHALL set the accumulated response to OKAY at acceptance; any non-OKAY m_bresp SHALL overwrite it (last non-OKAY wins).
REQ-018 SHALL drive s_bvalid high with the accumulated response the cycle after the final B handshake, holding it until s_bready.
REQ-019 Latency, zero wait states, single beat: SHALL give acceptance at cycle 0, m valids at cycle 1, m_bready at cycle 2, and s_bvalid one cycle after m_bvalid.
REQ-020 SHALL never assert m_awvalid for a new beat before the previous beat's B handshake (one outstanding transaction).

Reset
REQ-021 While rst_n is low, SHALL asynchronously force:
- state = IDLE and segment counter = 0.
- awready, wready, bvalid, m_awvalid, m_wvalid and m_bready = 0.
- bresp = 0, awaddr = 0, awprot = 0, wdata = 0 and wstrb = 0.
REQ-022 On reset mid-transaction, SHALL abandon the transaction with no s_bvalid issued.
REQ-023 SHALL raise s_awready/s_wready on the first clock after rst_n deasserts.

Structure
REQ-024 SHALL take the response codes (OKAY=0, SLVERR=2, DECERR=3) and the state encodings from the shared axil_pkg.
REQ-025 SHALL be implemented as a single module with no sub-module; segment select is inline indexing.

Verification
REQ-026 S=32, M=64: awaddr 0x4, wdata 0xAABBCCDD, wstrb 0xF -> m_awaddr 0x4, m_wdata 0xAABBCCDD_AABBCCDD, m_wstrb 0xF0; bresp OKAY forwarded.
REQ-027 S=64, M=32: awaddr 0x13, wdata 0x11223344_55667788, wstrb 0xFF -> two beats:
- Beat 0: awaddr 0x10, wdata 0x55667788, wstrb 0xF.
- Beat 1: awaddr 0x14, wdata 0x11223344, wstrb 0xF.
REQ-028 Narrow case with beat 0 bresp=2 and beat 1 bresp=0 -> s_bresp=2, with exactly one s_bvalid.
REQ-029 m_awready low for 3 cycles while m_wready is high -> W completes first, AW is held stable, and m_bready rises only after the AW handshake.
REQ-030 s_awvalid high with s_wvalid low -> no acceptance; rst_n pulsed low mid-DATA -> all valids 0 immediately, with IDLE and awready=1 one cycle after release.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared AXI-lite definitions: response codes, write-adapter state encoding, width helpers.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        STATE_IDLE = 2'd0,
        STATE_DATA = 2'd1,
        STATE_RESP = 2'd2
    } axil_wr_state_t;

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/axil_adapter_wr.sv
// AXI-lite write-channel width adapter: replicates narrow writes onto a wide bus or
// splits a wide write into sequential narrow beats, one outstanding beat at a time.
module axil_adapter_wr
    import axil_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned S_DATA_WIDTH = 32,
    parameter int unsigned S_STRB_WIDTH = S_DATA_WIDTH / 8,
    parameter int unsigned M_DATA_WIDTH = 32,
    parameter int unsigned M_STRB_WIDTH = M_DATA_WIDTH / 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic [2:0]              s_axil_awprot,
    input  logic                    s_axil_awvalid,
    output logic                    s_axil_awready,
    input  logic [S_DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [S_STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                    s_axil_wvalid,
    output logic                    s_axil_wready,
    output logic [1:0]              s_axil_bresp,
    output logic                    s_axil_bvalid,
    input  logic                    s_axil_bready,
    output logic [ADDR_WIDTH-1:0]   m_axil_awaddr,
    output logic [2:0]              m_axil_awprot,
    output logic                    m_axil_awvalid,
    input  logic                    m_axil_awready,
    output logic [M_DATA_WIDTH-1:0] m_axil_wdata,
    output logic [M_STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                    m_axil_wvalid,
    input  logic                    m_axil_wready,
    input  logic [1:0]              m_axil_bresp,
    input  logic                    m_axil_bvalid,
    output logic                    m_axil_bready
);

    localparam int unsigned S_ADDR_BIT_OFFSET = $clog2(S_STRB_WIDTH);
    localparam bit          EXPAND            = M_STRB_WIDTH > S_STRB_WIDTH;
    localparam bit          NARROW            = S_STRB_WIDTH > M_STRB_WIDTH;
    localparam int unsigned SEGMENT_COUNT     = EXPAND ? M_STRB_WIDTH / S_STRB_WIDTH
                                                       : S_STRB_WIDTH / M_STRB_WIDTH;
    localparam int unsigned SEG_W             = (SEGMENT_COUNT > 1) ? $clog2(SEGMENT_COUNT) : 1;

    if ((S_DATA_WIDTH != S_STRB_WIDTH * 8) || (M_DATA_WIDTH != M_STRB_WIDTH * 8) ||
        !is_pow2(S_STRB_WIDTH) || !is_pow2(M_STRB_WIDTH)) begin : g_bad_params
        $error("axil_adapter_wr: word size must be 8 bits and strobe widths powers of two");
    end

    axil_wr_state_t            state_q, state_d;
    logic [SEG_W-1:0]          seg_q, seg_d, seg_sel;
    logic                      s_awready_q, s_awready_d;
    logic                      s_wready_q, s_wready_d;
    logic                      s_bvalid_q, s_bvalid_d;
    logic [1:0]                s_bresp_q, s_bresp_d;
    logic [1:0]                resp_q, resp_d;
    logic [ADDR_WIDTH-1:0]     m_awaddr_q, m_awaddr_d;
    logic [2:0]                m_awprot_q, m_awprot_d;
    logic                      m_awvalid_q, m_awvalid_d;
    logic [M_DATA_WIDTH-1:0]   m_wdata_q, m_wdata_d;
    logic [M_STRB_WIDTH-1:0]   m_wstrb_q, m_wstrb_d;
    logic                      m_wvalid_q, m_wvalid_d;
    logic                      m_bready_q, m_bready_d;
    logic [S_DATA_WIDTH-1:0]   data_q, data_d;
    logic [S_STRB_WIDTH-1:0]   strb_q, strb_d;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= STATE_IDLE;
            seg_q       <= '0;
            s_awready_q <= 1'b0;
            s_wready_q  <= 1'b0;
            s_bvalid_q  <= 1'b0;
            s_bresp_q   <= '0;
            resp_q      <= '0;
            m_awaddr_q  <= '0;
            m_awprot_q  <= '0;
            m_awvalid_q <= 1'b0;
            m_wdata_q   <= '0;
            m_wstrb_q   <= '0;
            m_wvalid_q  <= 1'b0;
            m_bready_q  <= 1'b0;
            data_q      <= '0;
            strb_q      <= '0;
        end else begin
            state_q     <= state_d;
            seg_q       <= seg_d;
            s_awready_q <= s_awready_d;
            s_wready_q  <= s_wready_d;
            s_bvalid_q  <= s_bvalid_d;
            s_bresp_q   <= s_bresp_d;
            resp_q      <= resp_d;
            m_awaddr_q  <= m_awaddr_d;
            m_awprot_q  <= m_awprot_d;
            m_awvalid_q <= m_awvalid_d;
            m_wdata_q   <= m_wdata_d;
            m_wstrb_q   <= m_wstrb_d;
            m_wvalid_q  <= m_wvalid_d;
            m_bready_q  <= m_bready_d;
            data_q      <= data_d;
            strb_q      <= strb_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        seg_d       = seg_q;
        s_awready_d = s_awready_q;
        s_wready_d  = s_wready_q;
        s_bvalid_d  = s_bvalid_q;
        s_bresp_d   = s_bresp_q;
        resp_d      = resp_q;
        m_awaddr_d  = m_awaddr_q;
        m_awprot_d  = m_awprot_q;
        m_awvalid_d = m_awvalid_q;
        m_wdata_d   = m_wdata_q;
        m_wstrb_d   = m_wstrb_q;
        m_wvalid_d  = m_wvalid_q;
        m_bready_d  = m_bready_q;
        data_d      = data_q;
        strb_d      = strb_q;
        seg_sel     = EXPAND ? SEG_W'(s_axil_awaddr >> S_ADDR_BIT_OFFSET) : '0;

        unique case (state_q)
            STATE_IDLE: begin
                s_bvalid_d = s_bvalid_q && !s_axil_bready;
                if (s_awready_q && s_wready_q && s_axil_awvalid && s_axil_wvalid) begin
                    s_awready_d = 1'b0;
                    s_wready_d  = 1'b0;
                    m_awaddr_d  = NARROW ? (s_axil_awaddr & ~ADDR_WIDTH'(S_STRB_WIDTH - 1))
                                         : s_axil_awaddr;
                    m_awprot_d  = s_axil_awprot;
                    data_d      = s_axil_wdata;
                    strb_d      = s_axil_wstrb;
                    if (EXPAND) begin
                        m_wdata_d = M_DATA_WIDTH'({SEGMENT_COUNT{s_axil_wdata}});
                        m_wstrb_d = M_STRB_WIDTH'(s_axil_wstrb) << (32'(seg_sel) * S_STRB_WIDTH);
                    end else begin
                        m_wdata_d = M_DATA_WIDTH'(s_axil_wdata);
                        m_wstrb_d = M_STRB_WIDTH'(s_axil_wstrb);
                    end
                    m_awvalid_d = 1'b1;
                    m_wvalid_d  = 1'b1;
                    seg_d       = '0;
                    resp_d      = RESP_OKAY;
                    state_d     = STATE_DATA;
                end else begin
                    s_awready_d = !s_bvalid_d;
                    s_wready_d  = !s_bvalid_d;
                end
            end
            STATE_DATA: begin
                m_awvalid_d = m_awvalid_q && !m_axil_awready;
                m_wvalid_d  = m_wvalid_q && !m_axil_wready;
                if (!m_awvalid_d && !m_wvalid_d) begin
                    m_bready_d = 1'b1;
                    state_d    = STATE_RESP;
                end
            end
            STATE_RESP: begin
                if (m_bready_q && m_axil_bvalid) begin
                    m_bready_d = 1'b0;
                    if (m_axil_bresp != RESP_OKAY) begin
                        resp_d = m_axil_bresp;
                    end
                    // Remaining narrow beats step through the captured wide word
                    if (NARROW && (seg_q != SEG_W'(SEGMENT_COUNT - 1))) begin
                        seg_d       = seg_q + 1'b1;
                        m_awaddr_d  = m_awaddr_q + ADDR_WIDTH'(M_STRB_WIDTH);
                        m_wdata_d   = M_DATA_WIDTH'(data_q >> (32'(seg_d) * M_DATA_WIDTH));
                        m_wstrb_d   = M_STRB_WIDTH'(strb_q >> (32'(seg_d) * M_STRB_WIDTH));
                        m_awvalid_d = 1'b1;
                        m_wvalid_d  = 1'b1;
                        state_d     = STATE_DATA;
                    end else begin
                        s_bvalid_d = 1'b1;
                        s_bresp_d  = resp_d;
                        state_d    = STATE_IDLE;
                    end
                end
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    assign s_axil_awready = s_awready_q;
    assign s_axil_wready  = s_wready_q;
    assign s_axil_bvalid  = s_bvalid_q;
    assign s_axil_bresp   = s_bresp_q;
    assign m_axil_awaddr  = m_awaddr_q;
    assign m_axil_awprot  = m_awprot_q;
    assign m_axil_awvalid = m_awvalid_q;
    assign m_axil_wdata   = m_wdata_q;
    assign m_axil_wstrb   = m_wstrb_q;
    assign m_axil_wvalid  = m_wvalid_q;
    assign m_axil_bready  = m_bready_q;

endmodule

// File: tb/tb_axil_adapter_wr.sv
// Bench for axil_adapter_wr: an expanding (32->64) and a narrowing (64->32) instance
// driven through scenario tasks, with expected beats and responses kept in queues.
module tb_axil_adapter_wr;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  prot;
        logic [63:0] data;
        logic [7:0]  strb;
    } beat_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    beat_t      e_beat_q[$];
    beat_t      n_beat_q[$];
    logic [1:0] e_resp_q[$];
    logic [1:0] n_resp_q[$];

    // expanding instance: S=32, M=64
    logic [31:0] e_s_awaddr;  logic [2:0] e_s_awprot; logic e_s_awvalid, e_s_awready;
    logic [31:0] e_s_wdata;   logic [3:0] e_s_wstrb;  logic e_s_wvalid, e_s_wready;
    logic [1:0]  e_s_bresp;   logic e_s_bvalid, e_s_bready;
    logic [31:0] e_m_awaddr;  logic [2:0] e_m_awprot; logic e_m_awvalid, e_m_awready;
    logic [63:0] e_m_wdata;   logic [7:0] e_m_wstrb;  logic e_m_wvalid, e_m_wready;
    logic [1:0]  e_m_bresp;   logic e_m_bvalid, e_m_bready;

    // narrowing instance: S=64, M=32
    logic [31:0] n_s_awaddr;  logic [2:0] n_s_awprot; logic n_s_awvalid, n_s_awready;
    logic [63:0] n_s_wdata;   logic [7:0] n_s_wstrb;  logic n_s_wvalid, n_s_wready;
    logic [1:0]  n_s_bresp;   logic n_s_bvalid, n_s_bready;
    logic [31:0] n_m_awaddr;  logic [2:0] n_m_awprot; logic n_m_awvalid, n_m_awready;
    logic [31:0] n_m_wdata;   logic [3:0] n_m_wstrb;  logic n_m_wvalid, n_m_wready;
    logic [1:0]  n_m_bresp;   logic n_m_bvalid, n_m_bready;

    axil_adapter_wr #(.ADDR_WIDTH(32), .S_DATA_WIDTH(32), .M_DATA_WIDTH(64)) dut_e (
        .clk(clk), .rst_n(rst_n),
        .s_axil_awaddr(e_s_awaddr), .s_axil_awprot(e_s_awprot),
        .s_axil_awvalid(e_s_awvalid), .s_axil_awready(e_s_awready),
        .s_axil_wdata(e_s_wdata), .s_axil_wstrb(e_s_wstrb),
        .s_axil_wvalid(e_s_wvalid), .s_axil_wready(e_s_wready),
        .s_axil_bresp(e_s_bresp), .s_axil_bvalid(e_s_bvalid), .s_axil_bready(e_s_bready),
        .m_axil_awaddr(e_m_awaddr), .m_axil_awprot(e_m_awprot),
        .m_axil_awvalid(e_m_awvalid), .m_axil_awready(e_m_awready),
        .m_axil_wdata(e_m_wdata), .m_axil_wstrb(e_m_wstrb),
        .m_axil_wvalid(e_m_wvalid), .m_axil_wready(e_m_wready),
        .m_axil_bresp(e_m_bresp), .m_axil_bvalid(e_m_bvalid), .m_axil_bready(e_m_bready)
    );

    axil_adapter_wr #(.ADDR_WIDTH(32), .S_DATA_WIDTH(64), .M_DATA_WIDTH(32)) dut_n (
        .clk(clk), .rst_n(rst_n),
        .s_axil_awaddr(n_s_awaddr), .s_axil_awprot(n_s_awprot),
        .s_axil_awvalid(n_s_awvalid), .s_axil_awready(n_s_awready),
        .s_axil_wdata(n_s_wdata), .s_axil_wstrb(n_s_wstrb),
        .s_axil_wvalid(n_s_wvalid), .s_axil_wready(n_s_wready),
        .s_axil_bresp(n_s_bresp), .s_axil_bvalid(n_s_bvalid), .s_axil_bready(n_s_bready),
        .m_axil_awaddr(n_m_awaddr), .m_axil_awprot(n_m_awprot),
        .m_axil_awvalid(n_m_awvalid), .m_axil_awready(n_m_awready),
        .m_axil_wdata(n_m_wdata), .m_axil_wstrb(n_m_wstrb),
        .m_axil_wvalid(n_m_wvalid), .m_axil_wready(n_m_wready),
        .m_axil_bresp(n_m_bresp), .m_axil_bvalid(n_m_bvalid), .m_axil_bready(n_m_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change and outputs are sampled on the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic e_send(input logic [31:0] addr, input logic [2:0] prot,
                          input logic [31:0] data, input logic [3:0] strb);
        int t = 0;
        while (!e_s_awready && t < 20) begin tick(); t++; end
        checks++;
        if (e_s_awready !== 1'b1)
            begin errors++; $display("FAIL e_send_ready got awready=%b want 1", e_s_awready); end
        e_s_awaddr = addr; e_s_awprot = prot; e_s_wdata = data; e_s_wstrb = strb;
        e_s_awvalid = 1'b1; e_s_wvalid = 1'b1;
        tick();
        e_s_awvalid = 1'b0; e_s_wvalid = 1'b0;
        checks++;
        if (e_s_awready !== 1'b0 || e_s_wready !== 1'b0)
            begin errors++; $display("FAIL e_ready_drop got aw=%b w=%b want 0 0", e_s_awready, e_s_wready); end
    endtask

    task automatic n_send(input logic [31:0] addr, input logic [2:0] prot,
                          input logic [63:0] data, input logic [7:0] strb);
        int t = 0;
        while (!n_s_awready && t < 20) begin tick(); t++; end
        checks++;
        if (n_s_awready !== 1'b1)
            begin errors++; $display("FAIL n_send_ready got awready=%b want 1", n_s_awready); end
        n_s_awaddr = addr; n_s_awprot = prot; n_s_wdata = data; n_s_wstrb = strb;
        n_s_awvalid = 1'b1; n_s_wvalid = 1'b1;
        tick();
        n_s_awvalid = 1'b0; n_s_wvalid = 1'b0;
        checks++;
        if (n_s_awready !== 1'b0 || n_s_wready !== 1'b0)
            begin errors++; $display("FAIL n_ready_drop got aw=%b w=%b want 0 0", n_s_awready, n_s_wready); end
    endtask

    // Slave side of one master beat: W accepted first, AW after aw_stall cycles, then B
    task automatic e_serve_beat(input logic [1:0] resp, input int aw_stall);
        int t = 0;
        beat_t exp;
        while (!(e_m_awvalid && e_m_wvalid) && t < 20) begin tick(); t++; end
        checks++;
        if (!(e_m_awvalid === 1'b1 && e_m_wvalid === 1'b1))
            begin errors++; $display("FAIL e_beat_valid got aw=%b w=%b want 1 1", e_m_awvalid, e_m_wvalid); return; end
        checks++;
        if (e_beat_q.size() == 0)
            begin errors++; $display("FAIL e_beat_unexpected got beat addr=%h want none", e_m_awaddr); return; end
        exp = e_beat_q.pop_front();
        checks++;
        if (e_m_awaddr !== exp.addr) begin errors++; $display("FAIL e_awaddr got %h want %h", e_m_awaddr, exp.addr); end
        checks++;
        if (e_m_awprot !== exp.prot) begin errors++; $display("FAIL e_awprot got %h want %h", e_m_awprot, exp.prot); end
        checks++;
        if (e_m_wdata !== exp.data) begin errors++; $display("FAIL e_wdata got %h want %h", e_m_wdata, exp.data); end
        checks++;
        if (e_m_wstrb !== exp.strb) begin errors++; $display("FAIL e_wstrb got %h want %h", e_m_wstrb, exp.strb); end
        e_m_wready = 1'b1; e_m_awready = (aw_stall == 0);
        tick();
        e_m_wready = 1'b0;
        for (int i = 0; i < aw_stall; i++) begin
            checks++;
            if (e_m_awvalid !== 1'b1 || e_m_wvalid !== 1'b0 || e_m_bready !== 1'b0 || e_m_awaddr !== exp.addr)
                begin errors++; $display("FAIL e_aw_stall cyc%0d got aw=%b w=%b bready=%b addr=%h want 1 0 0 %h",
                                         i, e_m_awvalid, e_m_wvalid, e_m_bready, e_m_awaddr, exp.addr); end
            e_m_awready = (i == aw_stall - 1);
            tick();
        end
        e_m_awready = 1'b0;
        checks++;
        if (e_m_bready !== 1'b1 || e_m_awvalid !== 1'b0)
            begin errors++; $display("FAIL e_bready got bready=%b awvalid=%b want 1 0", e_m_bready, e_m_awvalid); end
        e_m_bvalid = 1'b1; e_m_bresp = resp;
        tick();
        e_m_bvalid = 1'b0; e_m_bresp = 2'd0;
    endtask

    task automatic n_serve_beat(input logic [1:0] resp);
        int t = 0;
        beat_t exp;
        while (!(n_m_awvalid && n_m_wvalid) && t < 20) begin tick(); t++; end
        checks++;
        if (!(n_m_awvalid === 1'b1 && n_m_wvalid === 1'b1))
            begin errors++; $display("FAIL n_beat_valid got aw=%b w=%b want 1 1", n_m_awvalid, n_m_wvalid); return; end
        checks++;
        if (n_beat_q.size() == 0)
            begin errors++; $display("FAIL n_beat_unexpected got beat addr=%h want none", n_m_awaddr); return; end
        exp = n_beat_q.pop_front();
        checks++;
        if (n_m_awaddr !== exp.addr) begin errors++; $display("FAIL n_awaddr got %h want %h", n_m_awaddr, exp.addr); end
        checks++;
        if (n_m_awprot !== exp.prot) begin errors++; $display("FAIL n_awprot got %h want %h", n_m_awprot, exp.prot); end
        checks++;
        if (n_m_wdata !== exp.data[31:0]) begin errors++; $display("FAIL n_wdata got %h want %h", n_m_wdata, exp.data[31:0]); end
        checks++;
        if (n_m_wstrb !== exp.strb[3:0]) begin errors++; $display("FAIL n_wstrb got %h want %h", n_m_wstrb, exp.strb[3:0]); end
        n_m_awready = 1'b1; n_m_wready = 1'b1;
        tick();
        n_m_awready = 1'b0; n_m_wready = 1'b0;
        checks++;
        if (n_m_bready !== 1'b1 || n_m_awvalid !== 1'b0)
            begin errors++; $display("FAIL n_bready got bready=%b awvalid=%b want 1 0", n_m_bready, n_m_awvalid); end
        n_m_bvalid = 1'b1; n_m_bresp = resp;
        tick();
        n_m_bvalid = 1'b0; n_m_bresp = 2'd0;
    endtask

    task automatic e_wait_resp(input int max_wait);
        int t = 0;
        logic [1:0] exp;
        while (!e_s_bvalid && t < max_wait) begin tick(); t++; end
        checks++;
        if (e_s_bvalid !== 1'b1) begin errors++; $display("FAIL e_bvalid got %b want 1 within %0d", e_s_bvalid, max_wait); return; end
        checks++;
        if (e_resp_q.size() == 0) begin errors++; $display("FAIL e_resp_unexpected got bresp=%h want none", e_s_bresp); return; end
        exp = e_resp_q.pop_front();
        checks++;
        if (e_s_bresp !== exp) begin errors++; $display("FAIL e_bresp got %h want %h", e_s_bresp, exp); end
        tick();
        checks++;
        if (e_s_bvalid !== 1'b1 || e_s_bresp !== exp)
            begin errors++; $display("FAIL e_bvalid_hold got %b/%h want 1/%h", e_s_bvalid, e_s_bresp, exp); end
        e_s_bready = 1'b1;
        tick();
        e_s_bready = 1'b0;
        checks++;
        if (e_s_bvalid !== 1'b0 || e_s_awready !== 1'b1)
            begin errors++; $display("FAIL e_bvalid_clear got bvalid=%b awready=%b want 0 1", e_s_bvalid, e_s_awready); end
    endtask

    task automatic n_wait_resp(input int max_wait);
        int t = 0;
        logic [1:0] exp;
        while (!n_s_bvalid && t < max_wait) begin tick(); t++; end
        checks++;
        if (n_s_bvalid !== 1'b1) begin errors++; $display("FAIL n_bvalid got %b want 1 within %0d", n_s_bvalid, max_wait); return; end
        checks++;
        if (n_resp_q.size() == 0) begin errors++; $display("FAIL n_resp_unexpected got bresp=%h want none", n_s_bresp); return; end
        exp = n_resp_q.pop_front();
        checks++;
        if (n_s_bresp !== exp) begin errors++; $display("FAIL n_bresp got %h want %h", n_s_bresp, exp); end
        n_s_bready = 1'b1;
        tick();
        n_s_bready = 1'b0;
        checks++;
        if (n_s_bvalid !== 1'b0 || n_s_awready !== 1'b1)
            begin errors++; $display("FAIL n_bvalid_clear got bvalid=%b awready=%b want 0 1", n_s_bvalid, n_s_awready); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        checks++;
        if (e_s_awready !== 1'b0 || e_s_wready !== 1'b0 || e_s_bvalid !== 1'b0 || e_s_bresp !== 2'd0)
            begin errors++; $display("FAIL reset_e_slave got %b%b%b %h want 000 0", e_s_awready, e_s_wready, e_s_bvalid, e_s_bresp); end
        checks++;
        if (e_m_awvalid !== 1'b0 || e_m_wvalid !== 1'b0 || e_m_bready !== 1'b0 || e_m_awaddr !== 32'd0 ||
            e_m_awprot !== 3'd0 || e_m_wdata !== 64'd0 || e_m_wstrb !== 8'd0)
            begin errors++; $display("FAIL reset_e_master got aw=%b w=%b b=%b addr=%h data=%h strb=%h want all 0",
                                     e_m_awvalid, e_m_wvalid, e_m_bready, e_m_awaddr, e_m_wdata, e_m_wstrb); end
        checks++;
        if (n_s_awready !== 1'b0 || n_m_awvalid !== 1'b0 || n_m_wvalid !== 1'b0 || n_m_bready !== 1'b0 ||
            n_m_awaddr !== 32'd0 || n_m_wdata !== 32'd0 || n_m_wstrb !== 4'd0)
            begin errors++; $display("FAIL reset_n got awready=%b aw=%b w=%b b=%b addr=%h want all 0",
                                     n_s_awready, n_m_awvalid, n_m_wvalid, n_m_bready, n_m_awaddr); end
        rst_n = 1'b1;
        tick();
        checks++;
        if (e_s_awready !== 1'b1 || e_s_wready !== 1'b1 || n_s_awready !== 1'b1 || n_s_wready !== 1'b1)
            begin errors++; $display("FAIL reset_release_ready got e=%b%b n=%b%b want 11 11",
                                     e_s_awready, e_s_wready, n_s_awready, n_s_wready); end
    endtask

    // Zero-wait single beat: valids one cycle after acceptance, s_bvalid one after m_bvalid
    task automatic test_expand_latency();
        e_beat_q.push_back('{addr: 32'h4, prot: 3'd0, data: 64'hAABBCCDD_AABBCCDD, strb: 8'hF0});
        e_resp_q.push_back(2'd0);
        e_send(32'h4, 3'd0, 32'hAABBCCDD, 4'hF);
        checks++;
        if (e_m_awvalid !== 1'b1 || e_m_wvalid !== 1'b1)
            begin errors++; $display("FAIL e_latency_valid got aw=%b w=%b want 1 1 at cycle 1", e_m_awvalid, e_m_wvalid); end
        e_serve_beat(2'd0, 0);
        e_wait_resp(0);
    endtask

    task automatic test_expand_table();
        logic [31:0] addr [3] = '{32'h0, 32'h6, 32'h10C};
        logic [31:0] data [3] = '{32'h12345678, 32'hCAFEF00D, 32'h0BADBEEF};
        logic [3:0]  strb [3] = '{4'h5, 4'h3, 4'h8};
        logic [7:0]  mstb [3] = '{8'h05, 8'h30, 8'h80};
        logic [1:0]  resp [3] = '{2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 3; i++) begin
            e_beat_q.push_back('{addr: addr[i], prot: 3'(i + 1), data: {data[i], data[i]}, strb: mstb[i]});
            e_resp_q.push_back(resp[i]);
            e_send(addr[i], 3'(i + 1), data[i], strb[i]);
            e_serve_beat(resp[i], 0);
            e_wait_resp(4);
        end
    endtask

    task automatic test_narrow();
        n_beat_q.push_back('{addr: 32'h10, prot: 3'd5, data: 64'h55667788, strb: 8'hF});
        n_beat_q.push_back('{addr: 32'h14, prot: 3'd5, data: 64'h11223344, strb: 8'hF});
        n_resp_q.push_back(2'd2);
        n_send(32'h13, 3'd5, 64'h11223344_55667788, 8'hFF);
        n_serve_beat(2'd2);
        checks++;
        if (n_s_bvalid !== 1'b0) begin errors++; $display("FAIL n_early_bvalid got %b want 0 between beats", n_s_bvalid); end
        n_serve_beat(2'd0);
        n_wait_resp(4);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (n_s_bvalid !== 1'b0 || n_m_awvalid !== 1'b0)
                begin errors++; $display("FAIL n_extra_activity got bvalid=%b awvalid=%b want 0 0", n_s_bvalid, n_m_awvalid); end
            tick();
        end
        // Zero-strobe low beat must still be issued; last non-OKAY response wins
        n_beat_q.push_back('{addr: 32'h8, prot: 3'd0, data: 64'hCAFEF00D, strb: 8'h0});
        n_beat_q.push_back('{addr: 32'hC, prot: 3'd0, data: 64'hDEADBEEF, strb: 8'hF});
        n_resp_q.push_back(2'd2);
        n_send(32'h8, 3'd0, 64'hDEADBEEF_CAFEF00D, 8'hF0);
        n_serve_beat(2'd3);
        n_serve_beat(2'd2);
        n_wait_resp(4);
    endtask

    task automatic test_aw_stall();
        e_beat_q.push_back('{addr: 32'h24, prot: 3'd2, data: 64'h01020304_01020304, strb: 8'hC0});
        e_resp_q.push_back(2'd0);
        e_send(32'h24, 3'd2, 32'h01020304, 4'hC);
        e_serve_beat(2'd0, 3);
        e_wait_resp(4);
    endtask

    task automatic test_no_accept();
        e_s_awvalid = 1'b1; e_s_wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (e_m_awvalid !== 1'b0 || e_s_awready !== 1'b1)
                begin errors++; $display("FAIL e_aw_only got m_awvalid=%b awready=%b want 0 1", e_m_awvalid, e_s_awready); end
        end
        e_s_awvalid = 1'b0; e_s_wvalid = 1'b1;
        tick();
        checks++;
        if (e_m_wvalid !== 1'b0 || e_s_wready !== 1'b1)
            begin errors++; $display("FAIL e_w_only got m_wvalid=%b wready=%b want 0 1", e_m_wvalid, e_s_wready); end
        e_s_wvalid = 1'b0;
    endtask

    task automatic test_reset_mid();
        n_beat_q.push_back('{addr: 32'h20, prot: 3'd0, data: 64'h0, strb: 8'h0});
        n_resp_q.push_back(2'd0);
        n_send(32'h20, 3'd0, 64'h0, 8'hFF);
        checks++;
        if (n_m_awvalid !== 1'b1) begin errors++; $display("FAIL n_mid_data got awvalid=%b want 1", n_m_awvalid); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (n_m_awvalid !== 1'b0 || n_m_wvalid !== 1'b0 || n_s_bvalid !== 1'b0 || n_m_bready !== 1'b0 ||
            n_s_awready !== 1'b0 || n_m_awaddr !== 32'd0)
            begin errors++; $display("FAIL n_async_reset got aw=%b w=%b bvalid=%b bready=%b awready=%b addr=%h want 0s",
                                     n_m_awvalid, n_m_wvalid, n_s_bvalid, n_m_bready, n_s_awready, n_m_awaddr); end
        n_beat_q.delete();
        n_resp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (n_s_awready !== 1'b1) begin errors++; $display("FAIL n_post_reset_ready got %b want 1", n_s_awready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (n_s_bvalid !== 1'b0 || n_m_awvalid !== 1'b0)
                begin errors++; $display("FAIL n_abandoned got bvalid=%b awvalid=%b want 0 0", n_s_bvalid, n_m_awvalid); end
        end
    endtask

    initial begin
        checks = 0; errors = 0; rst_n = 1'b0;
        e_s_awaddr = '0; e_s_awprot = '0; e_s_awvalid = 1'b0; e_s_wdata = '0; e_s_wstrb = '0;
        e_s_wvalid = 1'b0; e_s_bready = 1'b0; e_m_awready = 1'b0; e_m_wready = 1'b0;
        e_m_bresp = '0; e_m_bvalid = 1'b0;
        n_s_awaddr = '0; n_s_awprot = '0; n_s_awvalid = 1'b0; n_s_wdata = '0; n_s_wstrb = '0;
        n_s_wvalid = 1'b0; n_s_bready = 1'b0; n_m_awready = 1'b0; n_m_wready = 1'b0;
        n_m_bresp = '0; n_m_bvalid = 1'b0;
        @(negedge clk);
        test_reset();
        test_expand_latency();
        test_expand_table();
        test_narrow();
        test_aw_stall();
        test_no_accept();
        test_reset_mid();
        checks++;
        if (e_beat_q.size() != 0 || e_resp_q.size() != 0 || n_beat_q.size() != 0 || n_resp_q.size() != 0)
            begin errors++; $display("FAIL scoreboard_drain got %0d/%0d/%0d/%0d left want 0",
                                     e_beat_q.size(), e_resp_q.size(), n_beat_q.size(), n_resp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
